// File: rtl/comparador_tentativas_if.sv
// Bundle of guess, strobe and result signals between the keypad capture
// logic (master) and the guess comparator (slave).
interface comparador_tentativas_if #(
  parameter int WIDTH    = 4,
  parameter int MAX_TENT = 5
);
  localparam int TW = $clog2(MAX_TENT + 1);

  logic [WIDTH-1:0] senha;
  logic [WIDTH-1:0] tentativa;
  logic             valida;
  logic             novo_jogo;
  logic             igual;
  logic             perto;
  logic             errada;
  logic             maior;
  logic             resp_valida;
  logic             acertou;
  logic             bloqueado;
  logic [TW-1:0]    tent_rest;

  modport master (
    output senha, tentativa, valida, novo_jogo,
    input  igual, perto, errada, maior, resp_valida, acertou, bloqueado, tent_rest
  );

  modport slave (
    input  senha, tentativa, valida, novo_jogo,
    output igual, perto, errada, maior, resp_valida, acertou, bloqueado, tent_rest
  );
endinterface

// File: rtl/comparador_tentativas.sv
// Registered guess comparator: classifies each guess as exact/near/wrong with
// a direction hint, counts remaining attempts and tracks the game outcome.
module comparador_tentativas #(
  parameter int          WIDTH    = 4,
  parameter int unsigned TOL      = 3,
  parameter int          MAX_TENT = 5
) (
  input logic                 clk,
  input logic                 reset,
  comparador_tentativas_if.slave bus
);
  localparam int            TW    = $clog2(MAX_TENT + 1);
  localparam logic [TW-1:0] MAX_V = TW'(MAX_TENT);
  localparam logic [TW-1:0] UM    = TW'(1);

  typedef enum logic [1:0] {
    JOGANDO = 2'd0,
    GANHOU  = 2'd1,
    PERDEU  = 2'd2
  } estado_t;

  estado_t          estado_q;
  logic             pend_q;
  logic [WIDTH-1:0] senha_q;
  logic [WIDTH-1:0] palpite_q;
  logic             igual_q, perto_q, errada_q, maior_q;
  logic             resp_q, acertou_q, bloqueado_q;
  logic [TW-1:0]    tent_q;

  logic [WIDTH:0]   diff_d;
  logic [WIDTH:0]   mag_d;
  logic             igual_d, perto_d, errada_d, maior_d;
  logic             fim_d, aceita_d;

  // The captured guess is classified one cycle after acceptance; a pending
  // guess that will end the game blocks capture of the next strobe.
  always_comb begin
    diff_d   = {1'b0, palpite_q} - {1'b0, senha_q};
    mag_d    = diff_d[WIDTH] ? (~diff_d + (WIDTH+1)'(1)) : diff_d;
    igual_d  = (mag_d == '0);
    perto_d  = !igual_d && (32'(mag_d) <= TOL);
    errada_d = (32'(mag_d) > TOL);
    maior_d  = !diff_d[WIDTH] && !igual_d;
    fim_d    = pend_q && (igual_d || (tent_q == UM));
    aceita_d = bus.valida && !bus.novo_jogo && (estado_q == JOGANDO) && !fim_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q    <= JOGANDO;
      pend_q      <= 1'b0;
      senha_q     <= '0;
      palpite_q   <= '0;
      igual_q     <= 1'b0;
      perto_q     <= 1'b0;
      errada_q    <= 1'b0;
      maior_q     <= 1'b0;
      resp_q      <= 1'b0;
      acertou_q   <= 1'b0;
      bloqueado_q <= 1'b0;
      tent_q      <= MAX_V;
    end else begin
      resp_q <= 1'b0;
      pend_q <= aceita_d;
      if (aceita_d) begin
        senha_q   <= bus.senha;
        palpite_q <= bus.tentativa;
      end
      if (bus.novo_jogo) begin
        estado_q    <= JOGANDO;
        tent_q      <= MAX_V;
        igual_q     <= 1'b0;
        perto_q     <= 1'b0;
        errada_q    <= 1'b0;
        maior_q     <= 1'b0;
        acertou_q   <= 1'b0;
        bloqueado_q <= 1'b0;
      end else if (pend_q) begin
        igual_q  <= igual_d;
        perto_q  <= perto_d;
        errada_q <= errada_d;
        maior_q  <= maior_d;
        resp_q   <= 1'b1;
        tent_q   <= tent_q - UM;
        // A hit on the final attempt still counts as a win.
        if (igual_d) begin
          estado_q  <= GANHOU;
          acertou_q <= 1'b1;
        end else if (tent_q == UM) begin
          estado_q    <= PERDEU;
          bloqueado_q <= 1'b1;
        end
      end
    end
  end

  assign bus.igual       = igual_q;
  assign bus.perto       = perto_q;
  assign bus.errada      = errada_q;
  assign bus.maior       = maior_q;
  assign bus.resp_valida = resp_q;
  assign bus.acertou     = acertou_q;
  assign bus.bloqueado   = bloqueado_q;
  assign bus.tent_rest   = tent_q;
endmodule

// File: tb/tb_comparador_tentativas.sv
// Directed bench for comparador_tentativas: a small game model pushes expected
// results into a scoreboard which is popped when resp_valida pulses.
module tb_comparador_tentativas;
  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  comparador_tentativas_if #(.WIDTH(4), .MAX_TENT(5)) bus0 ();
  comparador_tentativas_if #(.WIDTH(6), .MAX_TENT(3)) bus1 ();

  comparador_tentativas #(.WIDTH(4), .TOL(3), .MAX_TENT(5)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  comparador_tentativas #(.WIDTH(6), .TOL(0), .MAX_TENT(3)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  typedef struct {
    bit igual, perto, errada, maior, acertou, bloqueado;
    int tent;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t cur;
  exp_t sb[$];

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelNewGame();
    cur = '{igual: 0, perto: 0, errada: 0, maior: 0, acertou: 0, bloqueado: 0, tent: 5};
  endtask

  task automatic modelGuess(input int s, input int g);
    int d, m;
    d = g - s;
    m = (d < 0) ? -d : d;
    cur.igual  = (m == 0);
    cur.perto  = (m >= 1 && m <= 3);
    cur.errada = (m > 3);
    cur.maior  = (d > 0);
    cur.tent   = cur.tent - 1;
    if (cur.igual) cur.acertou = 1;
    else if (cur.tent == 0) cur.bloqueado = 1;
  endtask

  // Compares every result output of the main instance with an expected record.
  task automatic compareAll(input string tag, input exp_t e);
    checkVal({tag, ".igual"},     32'(bus0.igual),     32'(e.igual));
    checkVal({tag, ".perto"},     32'(bus0.perto),     32'(e.perto));
    checkVal({tag, ".errada"},    32'(bus0.errada),    32'(e.errada));
    checkVal({tag, ".maior"},     32'(bus0.maior),     32'(e.maior));
    checkVal({tag, ".acertou"},   32'(bus0.acertou),   32'(e.acertou));
    checkVal({tag, ".bloqueado"}, 32'(bus0.bloqueado), 32'(e.bloqueado));
    checkVal({tag, ".tent_rest"}, 32'(bus0.tent_rest), 32'(e.tent));
  endtask

  // Drives one valida strobe (optionally with novo_jogo) and updates the model.
  task automatic applyStimulus(input int s, input int g, input bit nj);
    @(negedge clk);
    bus0.senha     = 4'(s);
    bus0.tentativa = 4'(g);
    bus0.valida    = 1'b1;
    bus0.novo_jogo = nj;
    if (nj) modelNewGame();
    else if (!cur.acertou && !cur.bloqueado) begin
      modelGuess(s, g);
      sb.push_back(cur);
    end
    @(posedge clk);
    #1;
    bus0.valida    = 1'b0;
    bus0.novo_jogo = 1'b0;
  endtask

  task automatic newGame();
    @(negedge clk);
    bus0.novo_jogo = 1'b1;
    modelNewGame();
    @(posedge clk);
    #1;
    bus0.novo_jogo = 1'b0;
  endtask

  // Waits (bounded) for the expected response or confirms that none appears.
  task automatic checkOutput(input string tag);
    exp_t e;
    int   lat;
    bit   seen;
    lat  = 0;
    seen = 0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int c = 1; c <= 4 && !seen; c++) begin
        @(posedge clk);
        #1;
        if (bus0.resp_valida === 1'b1) begin
          seen = 1;
          lat  = c;
        end
      end
      checkVal({tag, ".resp_seen"}, 32'(seen), 32'd1);
      checkVal({tag, ".latency"}, 32'(lat), 32'd1);
      compareAll(tag, e);
      @(posedge clk);
      #1;
      checkVal({tag, ".resp_pulse"}, 32'(bus0.resp_valida), 32'd0);
    end else begin
      for (int c = 1; c <= 3; c++) begin
        @(posedge clk);
        #1;
        if (bus0.resp_valida !== 1'b0) seen = 1;
      end
      checkVal({tag, ".no_resp"}, 32'(seen), 32'd0);
      compareAll(tag, cur);
    end
  endtask

  // One guess on the TOL=0 instance, with its expected flags and counter.
  task automatic applyB(input int s, input int g, input int expTent, input bit expBloq);
    bit seen;
    seen = 0;
    @(negedge clk);
    bus1.senha     = 6'(s);
    bus1.tentativa = 6'(g);
    bus1.valida    = 1'b1;
    @(posedge clk);
    #1;
    bus1.valida = 1'b0;
    for (int c = 1; c <= 4 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (bus1.resp_valida === 1'b1) seen = 1;
    end
    checkVal("tol0.resp_seen", 32'(seen), 32'd1);
    checkVal("tol0.errada", 32'(bus1.errada), 32'd1);
    checkVal("tol0.perto", 32'(bus1.perto), 32'd0);
    checkVal("tol0.igual", 32'(bus1.igual), 32'd0);
    checkVal("tol0.maior", 32'(bus1.maior), 32'(g > s));
    checkVal("tol0.tent_rest", 32'(bus1.tent_rest), 32'(expTent));
    checkVal("tol0.bloqueado", 32'(bus1.bloqueado), 32'(expBloq));
  endtask

  initial begin
    bus0.senha = '0; bus0.tentativa = '0; bus0.valida = 1'b0; bus0.novo_jogo = 1'b0;
    bus1.senha = '0; bus1.tentativa = '0; bus1.valida = 1'b0; bus1.novo_jogo = 1'b0;
    modelNewGame();
    repeat (2) @(posedge clk);
    #1;
    compareAll("reset", cur);
    checkVal("reset.resp", 32'(bus0.resp_valida), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Exact hit on the first attempt.
    applyStimulus(9, 9, 0);
    checkOutput("hit_first");

    // Near above, near below, wrong above.
    newGame();
    checkOutput("new1");
    applyStimulus(9, 12, 0);
    checkOutput("near_up");
    applyStimulus(9, 6, 0);
    checkOutput("near_down");
    applyStimulus(9, 13, 0);
    checkOutput("wrong_up");

    // Full-span differences in both directions.
    newGame();
    checkOutput("new2");
    applyStimulus(0, 15, 0);
    checkOutput("span_up");
    applyStimulus(15, 0, 0);
    checkOutput("span_down");

    // Lockout after five misses, then an ignored guess.
    newGame();
    checkOutput("new3");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(5, 0, 0);
      checkOutput($sformatf("miss%0d", i));
    end
    applyStimulus(5, 5, 0);
    checkOutput("locked_ignore");

    // Hit on the last attempt.
    newGame();
    checkOutput("new4");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(5, 1, 0);
      checkOutput($sformatf("pre_miss%0d", i));
    end
    applyStimulus(5, 5, 0);
    checkOutput("hit_last");
    newGame();
    checkOutput("new_after_win");

    // valida together with novo_jogo mid-game.
    applyStimulus(3, 7, 0);
    checkOutput("mid_guess");
    applyStimulus(3, 3, 1);
    checkOutput("valida_novo");

    // Asynchronous reset between edges discards a pending result.
    applyStimulus(3, 8, 0);
    reset = 1'b1;
    #1;
    sb.delete();
    modelNewGame();
    compareAll("async_reset", cur);
    checkVal("async_reset.resp", 32'(bus0.resp_valida), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("after_reset");

    // TOL=0 instance: one-away guess is wrong, three misses lock out.
    applyB(40, 41, 2, 0);
    applyB(40, 41, 1, 0);
    applyB(40, 39, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end
endmodule

// File: doc/comparador_tentativas.md
Name: comparador_tentativas

Overview:
Parametrised successor to the combinational guess comparator. It registers each guess against the secret code and classifies it as exact, near (within TOL) or wrong, with a direction hint. It counts the remaining attempts and runs the game outcome FSM (playing / won / locked out). It sits between the keypad/input capture logic and the display/LED driver.

Parameters:
WIDTH, 4, bit width of secret and guess (unsigned, >=2)
TOL, 3, max |guess - secret| classed as near; 0 disables near class
MAX_TENT, 5, attempts per game (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
senha  in  WIDTH  secret code, unsigned; sampled with valida
tentativa  in  WIDTH  guess, unsigned; sampled with valida
valida  in  1  one-cycle strobe: evaluate current guess
novo_jogo  in  1  one-cycle strobe: restart game
igual  out  1  last evaluated guess == secret
perto  out  1  last guess 1..TOL away from secret
errada  out  1  last guess more than TOL away
maior  out  1  last guess > secret (direction hint)
resp_valida  out  1  one-cycle pulse: result flags updated
acertou  out  1  game won (state GANHOU)
bloqueado  out  1  attempts exhausted without a hit (state PERDEU)
tent_rest  out  $clog2(MAX_TENT+1)  attempts remaining

Behaviour:
- Reset (async, active-high): state JOGANDO, tent_rest=MAX_TENT, igual=perto=errada=maior=0, resp_valida=0, acertou=bloqueado=0.
- Arithmetic: diff = {1'b0,tentativa} - {1'b0,senha}, WIDTH+1 bits, two's complement. mag = |diff|, with no overflow for any input pair.
- Classification: igual = (mag==0); perto = (1<=mag<=TOL); errada = (mag>TOL); maior = (diff>0). Exactly one of igual/perto/errada is 1 after the first evaluation. All four are 0 before it and after novo_jogo.
- Latency: valida sampled high in JOGANDO at edge N. Flags, tent_rest, state and resp_valida update at edge N+1. resp_valida is high for exactly one cycle.
- Flags hold their last value until the next accepted valida or novo_jogo.
- FSM:
  - JOGANDO + valida: tent_rest -= 1. If igual, go to GANHOU. Else if the new tent_rest==0, go to PERDEU. Else stay in JOGANDO.
  - A hit on the last attempt goes to GANHOU, not PERDEU.
  - GANHOU / PERDEU: valida is ignored. No resp_valida, flags and tent_rest are frozen.
  - Any state + novo_jogo: go to JOGANDO, tent_rest=MAX_TENT, all flags cleared, resp_valida=0.
- acertou = (state==GANHOU); bloqueado = (state==PERDEU). Both are registered, never high together.
- valida and novo_jogo in the same cycle: novo_jogo wins and the guess is discarded.
- valida held high for several cycles: each cycle is a separate attempt. Upstream must deliver one-cycle strobes.
- tent_rest never underflows; it saturates at 0 in PERDEU.
- Reset asserted mid-game takes effect immediately and asynchronously. Any pending result is lost.
- Not checked: the legal-mode flag (TOL >= 2^WIDTH makes every non-equal guess near) is the integrator's concern.

Test Plan:
- Defaults. Reset, then senha=9, tentativa=9, valida pulse -> next cycle: igual=1, perto=0, errada=0, maior=0, resp_valida=1 for 1 cycle, acertou=1, tent_rest=4.
- senha=9. Guesses 12, then 6, then 13 -> respectively perto=1,maior=1 / perto=1,maior=0 / errada=1,maior=1. tent_rest goes 4,3,2.
- Wide span. senha=0, tentativa=15 -> errada=1, maior=1. senha=15, tentativa=0 -> errada=1, maior=0 (no overflow).
- senha=5, five guesses of 0 -> bloqueado=1 after the 5th, tent_rest=0. A 6th valida with tentativa=5 -> no resp_valida, flags and counter unchanged.
- Hit on the last attempt (4 misses, then tentativa=senha) -> acertou=1, bloqueado=0, tent_rest=0. Then novo_jogo -> JOGANDO, tent_rest=5, all flags 0.
- valida+novo_jogo in the same cycle mid-game -> no resp_valida, tent_rest=5. Reset asserted between edges -> outputs go to reset values immediately, without a clock edge.
- TOL=0, WIDTH=6, MAX_TENT=3 instance: senha=40, tentativa=41 -> errada=1 (perto never set). Three misses -> bloqueado=1.
